tile_readout_sequencer: RTL and testbench

//  gpu_clk-side front end of tile write-back: after a buffer swap, walks the read half of the

---
 rtl/gpu_pkg.sv | 24 ++
 rtl/tr_skid2.sv | 48 ++++
 rtl/tile_readout_sequencer.sv | 134 +++++++++++++
 tb/tb_tile_readout_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gpu_pkg                                                                  |
// | Tile geometry, write-back entry layout and read-out sequencer states.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package gpu_pkg;
  localparam int TILE_WORDS    = 512;
  localparam int WORDS_PER_ROW = 16;
  localparam int ROWS          = 32;

  // Shared with the clk-side tile master: one write-FIFO entry.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } trs_state_t;
endpackage
`default_nettype wire

// File: rtl/tr_skid2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tr_skid2                                                                 |
// | Two-entry FIFO between the tile RAM read pipe and the write FIFO.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tr_skid2 #(
  parameter int WIDTH = 64
) (
  input  logic             gpu_clk,
  input  logic             gpu_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count,
  output logic             empty
);
  logic [WIDTH-1:0] r_mem [2];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_count;

  // Caller guarantees no push when full and no pop when empty.
  always_ff @(posedge gpu_clk or posedge gpu_rst) begin
    if (gpu_rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + 2'(push) - 2'(pop);
    end
  end

  assign head_data = r_mem[r_rd_ptr];
  assign count     = r_count;
  assign empty     = (r_count == 2'd0);
endmodule
`default_nettype wire

// File: rtl/tile_readout_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tile_readout_sequencer                                                   |
// | Walks the read half of the tile RAM and pushes {address,data} entries.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tile_readout_sequencer #(
  parameter int WORDS_PER_ROW = 16,
  parameter int ROWS          = 32,
  parameter int RAM_AW        = 9,
  parameter int ADDR_W        = 32
) (
  input  logic                gpu_clk,
  input  logic                gpu_rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   addr_in,
  input  logic [15:0]         stride_in,
  output logic [RAM_AW-1:0]   ram_addr_out,
  input  logic [31:0]         ram_data,
  output logic                fifo_wrreq,
  output logic [ADDR_W+31:0]  fifo_data,
  input  logic                fifo_full,
  input  logic                drain_idle,
  output logic                reading,
  output logic                flushed
);
  import gpu_pkg::*;

  localparam int COL_W = $clog2(WORDS_PER_ROW);
  localparam int TOTAL = WORDS_PER_ROW * ROWS;

  trs_state_t        r_state;
  logic [RAM_AW:0]   r_idx;
  logic [ADDR_W-1:0] r_row_base;
  logic [15:0]       r_stride;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_infl_addr;
  logic              r_reading;
  logic              r_flushed;

  logic [ADDR_W-1:0] w_issue_addr;
  logic [2:0]        w_occ;
  logic              w_issue;
  logic              w_pop;
  logic              w_last_cap;
  logic              w_skid_empty;
  logic [1:0]        w_skid_count;
  logic [ADDR_W+31:0] w_skid_head;
  wb_entry_t         w_cap;

  assign w_pop = !w_skid_empty && !fifo_full;

  // Occupancy after this cycle's pop; counting the pop keeps 1 word/cycle flowing.
  assign w_occ = {1'b0, w_skid_count} + {2'b00, r_inflight} - {2'b00, w_pop};

  assign w_issue = (r_state == ST_READ) && (r_idx < (RAM_AW + 1)'(TOTAL)) && (w_occ < 3'd2);

  assign w_issue_addr = r_row_base + ADDR_W'({r_idx[COL_W-1:0], 2'b00});

  // r_inflight always carries the most recently issued word (idx-1).
  assign w_last_cap = r_inflight && (r_idx == (RAM_AW + 1)'(TOTAL));

  assign w_cap.addr = r_infl_addr;
  assign w_cap.data = ram_data;

  always_ff @(posedge gpu_clk or posedge gpu_rst) begin
    if (gpu_rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_row_base  <= '0;
      r_stride    <= '0;
      r_inflight  <= 1'b0;
      r_infl_addr <= '0;
      r_reading   <= 1'b0;
      r_flushed   <= 1'b1;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_idx       <= r_idx + 1'b1;
        r_infl_addr <= w_issue_addr;
        if (&r_idx[COL_W-1:0]) begin
          r_row_base <= r_row_base + ADDR_W'(r_stride);
        end
      end

      r_flushed <= (r_state == ST_IDLE) && w_skid_empty && drain_idle;

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_READ;
            r_idx      <= '0;
            r_row_base <= addr_in;
            r_stride   <= stride_in;
            r_reading  <= 1'b1;
            r_flushed  <= 1'b0;
          end
        end
        ST_READ: begin
          if (w_last_cap) begin
            r_state   <= ST_DRAIN;
            r_reading <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (w_skid_empty) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  tr_skid2 #(
    .WIDTH(ADDR_W + 32)
  ) u_skid (
    .gpu_clk   (gpu_clk),
    .gpu_rst   (gpu_rst),
    .push      (r_inflight),
    .push_data (w_cap),
    .pop       (w_pop),
    .head_data (w_skid_head),
    .count     (w_skid_count),
    .empty     (w_skid_empty)
  );

  assign ram_addr_out = r_idx[RAM_AW-1:0];
  assign fifo_wrreq   = w_pop;
  assign fifo_data    = w_skid_head;
  assign reading      = r_reading;
  assign flushed      = r_flushed;
endmodule
`default_nettype wire

// File: tb/tb_tile_readout_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tile_readout_sequencer                                                |
// | Scoreboarded tile read-out bench with a tile-RAM model.                  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_tile_readout_sequencer;
  logic        gpu_clk = 1'b0;
  logic        gpu_rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] addr_in = '0;
  logic [15:0] stride_in = '0;
  logic [8:0]  ram_addr_out;
  logic [31:0] ram_data;
  logic        fifo_wrreq;
  logic [63:0] fifo_data;
  logic        fifo_full = 1'b0;
  logic        drain_idle = 1'b1;
  logic        reading;
  logic        flushed;

  int          n_vec = 0;
  int          n_err = 0;
  int          full_pct_g = 0;
  int          log_n = 0;
  logic [31:0] log_addr [1024];
  logic [31:0] ram [512];
  logic [63:0] exp_q [$];
  logic [63:0] mon_exp;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] stride;
    int          full_pct;
    int          i0;
    logic [31:0] a0;
    int          i1;
    logic [31:0] a1;
    int          i2;
    logic [31:0] a2;
  } vec_t;
  vec_t vecs [4];

  tile_readout_sequencer dut (
    .gpu_clk      (gpu_clk),
    .gpu_rst      (gpu_rst),
    .start        (start),
    .addr_in      (addr_in),
    .stride_in    (stride_in),
    .ram_addr_out (ram_addr_out),
    .ram_data     (ram_data),
    .fifo_wrreq   (fifo_wrreq),
    .fifo_data    (fifo_data),
    .fifo_full    (fifo_full),
    .drain_idle   (drain_idle),
    .reading      (reading),
    .flushed      (flushed)
  );

  initial forever #5 gpu_clk = ~gpu_clk;

  // Tile RAM with one-cycle registered read.
  always @(posedge gpu_clk) ram_data <= ram[ram_addr_out];

  initial forever begin
    @(posedge gpu_clk);
    #1;
    fifo_full = (full_pct_g > 0) && (int'($urandom_range(0, 99)) < full_pct_g);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge gpu_clk) begin
    if (fifo_wrreq) begin
      chk("push_while_full", 64'(fifo_full), 64'd0);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_push: got %h expected no push at %0t", fifo_data, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("push_entry", fifo_data, mon_exp);
      end
      if (log_n < 1024) log_addr[log_n] = fifo_data[63:32];
      log_n++;
    end
  end

  // mode 0: normal, 1: extra start pulse near word 100, 2: return near word 100.
  task automatic run_tile(input logic [31:0] base, input logic [15:0] stride, input int pct,
                          input int mode, input bit wait_flush);
    logic [31:0] a;
    int          n;
    int          fall;
    bit          did;
    bit          done;
    for (int i = 0; i < 512; i++) ram[i] = $urandom();
    log_n = 0;
    for (int i = 0; i < 512; i++) begin
      a = base + 32'(i / 16) * {16'h0, stride} + 32'(i % 16) * 32'd4;
      exp_q.push_back({a, ram[i]});
    end
    full_pct_g = pct;
    @(negedge gpu_clk);
    addr_in   = base;
    stride_in = stride;
    start     = 1'b1;
    @(posedge gpu_clk);
    #1;
    start     = 1'b0;
    addr_in   = 32'hDEADBEEF;
    stride_in = 16'h1234;
    @(negedge gpu_clk);
    chk("reading_rise", 64'(reading), 64'd1);
    chk("flushed_forced_low", 64'(flushed), 64'd0);
    n = 0;
    fall = -1;
    did = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge gpu_clk);
      n++;
      @(negedge gpu_clk);
      if (start) start = 1'b0;
      if (!reading && fall < 0) fall = n;
      if (mode == 1 && !did && log_n >= 100) begin
        start     = 1'b1;
        addr_in   = 32'h99990000;
        stride_in = 16'h0010;
        did       = 1'b1;
      end
      if (mode == 2 && log_n >= 100) return;
      if (log_n >= 512 && (flushed || !wait_flush)) begin
        done = 1'b1;
        break;
      end
    end
    start = 1'b0;
    full_pct_g = 0;
    chk("tile_done", 64'(done), 64'd1);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    if (pct == 0 && mode == 0) chk("reading_fall_cycle", 64'(fall), 64'd513);
  endtask

  initial begin
    vecs[0] = '{32'h00001000, 16'h0800, 0,  0, 32'h00001000, 16, 32'h00001800, 511, 32'h0001083C};
    vecs[1] = '{32'h00001000, 16'h0800, 50, 0, 32'h00001000, 16, 32'h00001800, 511, 32'h0001083C};
    vecs[2] = '{32'hFFFFF000, 16'h0800, 0,  0, 32'hFFFFF000, 32, 32'h00000000, 511, 32'h0000E83C};
    vecs[3] = '{32'h00002000, 16'h0000, 30, 0, 32'h00002000, 16, 32'h00002000, 511, 32'h0000203C};

    repeat (3) @(posedge gpu_clk);
    @(negedge gpu_clk);
    chk("rst_ram_addr", 64'(ram_addr_out), 64'd0);
    chk("rst_wrreq", 64'(fifo_wrreq), 64'd0);
    chk("rst_fifo_data", fifo_data, 64'd0);
    chk("rst_reading", 64'(reading), 64'd0);
    chk("rst_flushed", 64'(flushed), 64'd1);
    gpu_rst = 1'b0;
    repeat (2) @(negedge gpu_clk);
    chk("idle_flushed", 64'(flushed), 64'd1);

    for (int v = 0; v < 4; v++) begin
      run_tile(vecs[v].addr, vecs[v].stride, vecs[v].full_pct, 0, 1'b1);
      chk("vec_addr_a", 64'(log_addr[vecs[v].i0]), 64'(vecs[v].a0));
      chk("vec_addr_b", 64'(log_addr[vecs[v].i1]), 64'(vecs[v].a1));
      chk("vec_addr_c", 64'(log_addr[vecs[v].i2]), 64'(vecs[v].a2));
    end

    // Write master still busy after the last push: flushed must wait for it.
    drain_idle = 1'b0;
    run_tile(32'h00003000, 16'h0100, 0, 0, 1'b0);
    for (int c = 0; c < 20; c++) begin
      @(negedge gpu_clk);
      chk("flushed_held_low", 64'(flushed), 64'd0);
    end
    drain_idle = 1'b1;
    @(negedge gpu_clk);
    chk("flushed_rise", 64'(flushed), 64'd1);

    // Extra start mid-tile must not disturb the sequence.
    run_tile(32'h00005000, 16'h0800, 25, 1, 1'b1);

    // Reset in the middle of a tile, then a fresh tile from idx 0.
    run_tile(32'h00006000, 16'h0800, 0, 2, 1'b1);
    gpu_rst = 1'b1;
    #1;
    chk("midrst_ram_addr", 64'(ram_addr_out), 64'd0);
    chk("midrst_wrreq", 64'(fifo_wrreq), 64'd0);
    chk("midrst_fifo_data", fifo_data, 64'd0);
    chk("midrst_reading", 64'(reading), 64'd0);
    chk("midrst_flushed", 64'(flushed), 64'd1);
    @(posedge gpu_clk);
    @(negedge gpu_clk);
    gpu_rst = 1'b0;
    exp_q.delete();
    @(negedge gpu_clk);
    run_tile(32'h00007000, 16'h0040, 0, 0, 1'b1);
    chk("restart_first_addr", 64'(log_addr[0]), 64'h7000);
    chk("restart_row1_addr", 64'(log_addr[16]), 64'h7040);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: got no completion expected completion");
    $fatal(1);
  end
endmodule
`default_nettype wire
